// File: rtl/tile_rom_arbiter.sv
// tile_rom_arbiter: shares the single tile graphics ROM port between the
// deadline-critical video tile fetch and the stall-tolerant CPU readback.
// Video wins arbitration; a streak counter hands the port to a waiting CPU
// request after STARVE_MAX consecutive video grants.
// Optional build macro: TILE_ROM_ARB_HITCACHE_EN adds a one-entry video
// last-address cache that answers repeated fetches without a memory access.
module tile_rom_arbiter #(
    parameter int AW         = 18,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk_main,
    input  logic          reset,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [DW-1:0] vid_dout,
    output logic          vid_valid,
    output logic          vid_drop,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    output logic [DW-1:0] cpu_dout,
    output logic          cpu_ack,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_data,
    input  logic          mem_rdy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_VID  = 2'd1,
        ST_CPU  = 2'd2
    } state_t;

    localparam logic [3:0] STREAK_MAX = 4'(STARVE_MAX);

    state_t        state_reg;
    state_t        state_next;
    logic          grant_vid;
    logic          grant_cpu;

    logic          vid_pend_reg;
    logic [AW-1:0] vid_addr_reg;
    logic          vid_drop_reg;
    logic          cpu_done_reg;
    logic [3:0]    streak_reg;
    logic [AW-1:0] mem_addr_reg;
    logic [DW-1:0] vid_dout_reg;
    logic [DW-1:0] cpu_dout_reg;
    logic          vid_valid_reg;
    logic          cpu_ack_reg;

    // Completion of the transaction currently on the memory port. A mem_rdy
    // seen while idle (e.g. a straggler after reset) matches neither.
    logic          vid_fin;
    logic          cpu_fin;
    logic          vid_hit;
    logic          vid_new;
    logic          vid_pend_eff;
    logic [AW-1:0] vid_addr_eff;
    logic          cpu_pend;

    assign vid_fin = (state_reg == ST_VID) && mem_rdy;
    assign cpu_fin = (state_reg == ST_CPU) && mem_rdy;

`ifdef TILE_ROM_ARB_HITCACHE_EN
    logic [AW-1:0] last_addr_reg;
    logic          cache_valid_reg;

    // A hit is refused on the cycle a video fetch completes, because the
    // held data is about to be replaced by a different address.
    assign vid_hit = vid_req && cache_valid_reg && !vid_fin
                  && (vid_addr == last_addr_reg);

    // Remember the address whose data vid_dout currently holds.
    always_ff @(posedge clk_main) begin
        if (reset) begin
            last_addr_reg   <= '0;
            cache_valid_reg <= 1'b0;
        end else if (vid_fin) begin
            last_addr_reg   <= mem_addr_reg;
            cache_valid_reg <= 1'b1;
        end
    end
`else
    assign vid_hit = 1'b0;
`endif

    // Requests that need the memory port; a same-cycle strobe is folded in
    // so an idle arbiter raises mem_req on the very next cycle.
    assign vid_new      = vid_req && !vid_hit;
    assign vid_pend_eff = vid_pend_reg || vid_new;
    assign vid_addr_eff = vid_new ? vid_addr : vid_addr_reg;
    assign cpu_pend     = cpu_req && !cpu_done_reg;

    // FSM state register.
    always_ff @(posedge clk_main) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Arbitration and next-state: grants are only made from IDLE, and a
    // busy state is held until the memory answers.
    always_comb begin
        state_next = state_reg;
        grant_vid  = 1'b0;
        grant_cpu  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (cpu_pend && (!vid_pend_eff || (streak_reg == STREAK_MAX))) begin
                    state_next = ST_CPU;
                    grant_cpu  = 1'b1;
                end else if (vid_pend_eff) begin
                    state_next = ST_VID;
                    grant_vid  = 1'b1;
                end
            end
            ST_VID: begin
                if (mem_rdy) begin
                    state_next = ST_IDLE;
                end
            end
            ST_CPU: begin
                if (mem_rdy) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Video pending slot: latest request wins, overwriting an unissued one
    // raises the sticky drop flag.
    always_ff @(posedge clk_main) begin
        if (reset) begin
            vid_pend_reg <= 1'b0;
            vid_addr_reg <= '0;
            vid_drop_reg <= 1'b0;
        end else begin
            if (grant_vid) begin
                vid_pend_reg <= 1'b0;
            end else if (vid_new) begin
                vid_pend_reg <= 1'b1;
            end
            if (vid_new) begin
                vid_addr_reg <= vid_addr;
            end
            if (vid_new && vid_pend_reg) begin
                vid_drop_reg <= 1'b1;
            end
        end
    end

    // Issue address, captured at grant so it stays fixed while mem_req is up.
    always_ff @(posedge clk_main) begin
        if (reset) begin
            mem_addr_reg <= '0;
        end else if (grant_vid) begin
            mem_addr_reg <= vid_addr_eff;
        end else if (grant_cpu) begin
            mem_addr_reg <= cpu_addr;
        end
    end

    // Starvation streak: counts video grants taken past a waiting CPU.
    always_ff @(posedge clk_main) begin
        if (reset) begin
            streak_reg <= 4'd0;
        end else if (!cpu_pend || grant_cpu) begin
            streak_reg <= 4'd0;
        end else if (grant_vid && (streak_reg < STREAK_MAX)) begin
            streak_reg <= streak_reg + 4'd1;
        end
    end

    // CPU re-arm: one ack per cpu_req assertion. Setting on completion (not
    // one cycle later) keeps IDLE from re-granting during the ack cycle.
    always_ff @(posedge clk_main) begin
        if (reset) begin
            cpu_done_reg <= 1'b0;
        end else if (!cpu_req) begin
            cpu_done_reg <= 1'b0;
        end else if (cpu_fin) begin
            cpu_done_reg <= 1'b1;
        end
    end

    // Return data and completion pulses for both requesters.
    always_ff @(posedge clk_main) begin
        if (reset) begin
            vid_dout_reg  <= '0;
            cpu_dout_reg  <= '0;
            vid_valid_reg <= 1'b0;
            cpu_ack_reg   <= 1'b0;
        end else begin
            vid_valid_reg <= vid_fin || vid_hit;
            cpu_ack_reg   <= cpu_fin;
            if (vid_fin) begin
                vid_dout_reg <= mem_data;
            end
            if (cpu_fin) begin
                cpu_dout_reg <= mem_data;
            end
        end
    end

    assign mem_req   = (state_reg != ST_IDLE);
    assign mem_addr  = mem_addr_reg;
    assign vid_dout  = vid_dout_reg;
    assign vid_valid = vid_valid_reg;
    assign vid_drop  = vid_drop_reg;
    assign cpu_dout  = cpu_dout_reg;
    assign cpu_ack   = cpu_ack_reg;

endmodule
